// File: rtl/fwrisc_trace_pkg.sv
// Types shared by the retire-trace generator and its record FIFO.
//   trace_rec_t   : one retired-instruction record (every trc_* payload field)
//   trace_state_e : collector FSM state
//   fresh_rec()   : record for a newly started instruction (pc/instr set, all else cleared)
package fwrisc_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  ra_raddr;
    logic [31:0] ra_rdata;
    logic [5:0]  rb_raddr;
    logic [31:0] rb_rdata;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        rd_write;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [3:0]  mstrb;
    logic        mwrite;
    logic        mvalid;
  } trace_rec_t;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } trace_state_e;

  function automatic trace_rec_t fresh_rec(logic [31:0] pc, logic [31:0] instr);
    trace_rec_t r;
    r       = '0;
    r.pc    = pc;
    r.instr = instr;
    return r;
  endfunction

endpackage

// File: rtl/fwrisc_trace_fifo.sv
// Retire-record FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/rec_i  : record to enqueue
//   pop_i         : consumer accepts the head (ignored when empty)
//   rec_o/valid_o : head record (forced to zero while empty) and not-empty
//   drop_o        : a push was discarded because the FIFO was full
// DEPTH must be a power of two (2..8) so the pointers wrap naturally.
module fwrisc_trace_fifo
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  trace_rec_t rec_i,
  input  logic       pop_i,
  output trace_rec_t rec_o,
  output logic       valid_o,
  output logic       drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          full, do_pop, do_push;

  assign valid_o = (cnt_q != '0);
  assign full    = (cnt_q == CNT_FULL);
  assign do_pop  = pop_i && valid_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;
  // Gating keeps the outputs at zero after reset without clearing the storage.
  assign rec_o   = valid_o ? mem_q[rd_q] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= rec_i;
  end

endmodule

// File: rtl/fwrisc_trace_gen.sv
// Instruction retire-trace generator.
// Collects the register reads, register write-back and data-bus transfer of
// each instruction between instr_start and instr_done, then queues the
// assembled record for the trace consumer.
//   clock, reset        : clock, asynchronous active-low reset
//   instr_start/pc_i/instr_i       : new instruction begins
//   ra_*/rb_*           : register read ports
//   rd_we/rd_waddr_i/rd_wdata_i    : register write-back (x0 ignored)
//   mvalid_i/mready_i/...          : data-bus handshake
//   instr_done          : instruction retired
//   trc_ready / trc_*   : record stream (trc_ivalid = record present)
//   overflow, protocol_err         : sticky error flags
module fwrisc_trace_gen
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_start,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        ra_rd_v,
  input  logic        rb_rd_v,
  input  logic [5:0]  ra_raddr_i,
  input  logic [5:0]  rb_raddr_i,
  input  logic [31:0] ra_rdata_i,
  input  logic [31:0] rb_rdata_i,
  input  logic        rd_we,
  input  logic [5:0]  rd_waddr_i,
  input  logic [31:0] rd_wdata_i,
  input  logic        mvalid_i,
  input  logic        mready_i,
  input  logic        mwrite_i,
  input  logic [31:0] maddr_i,
  input  logic [31:0] mdata_i,
  input  logic [3:0]  mstrb_i,
  input  logic        instr_done,
  input  logic        trc_ready,
  output logic [31:0] trc_pc,
  output logic [31:0] trc_instr,
  output logic        trc_ivalid,
  output logic [5:0]  trc_ra_raddr,
  output logic [5:0]  trc_rb_raddr,
  output logic [5:0]  trc_rd_waddr,
  output logic [31:0] trc_ra_rdata,
  output logic [31:0] trc_rb_rdata,
  output logic [31:0] trc_rd_wdata,
  output logic        trc_rd_write,
  output logic [31:0] trc_maddr,
  output logic [31:0] trc_mdata,
  output logic [3:0]  trc_mstrb,
  output logic        trc_mwrite,
  output logic        trc_mvalid,
  output logic        overflow,
  output logic        protocol_err
);

  trace_state_e state_q, state_d;
  trace_rec_t   rec_q, rec_d, rec_upd, head;
  logic         push, drop, perr_set;
  logic         ovf_q, perr_q;

  // Current record with this cycle's events folded in; used both to keep
  // collecting and as the retiring record, so same-cycle events are included.
  always_comb begin
    rec_upd = rec_q;
    if (ra_rd_v) begin
      rec_upd.ra_raddr = ra_raddr_i;
      rec_upd.ra_rdata = ra_rdata_i;
    end
    if (rb_rd_v) begin
      rec_upd.rb_raddr = rb_raddr_i;
      rec_upd.rb_rdata = rb_rdata_i;
    end
    if (rd_we && (rd_waddr_i != '0)) begin
      rec_upd.rd_waddr = rd_waddr_i;
      rec_upd.rd_wdata = rd_wdata_i;
      rec_upd.rd_write = 1'b1;
    end
    if (mvalid_i && mready_i) begin
      rec_upd.maddr  = maddr_i;
      rec_upd.mdata  = mdata_i;
      rec_upd.mstrb  = mstrb_i;
      rec_upd.mwrite = mwrite_i;
      rec_upd.mvalid = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    push     = 1'b0;
    perr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_done) perr_set = 1'b1;
        if (instr_start) begin
          state_d = ST_COLLECT;
          rec_d   = fresh_rec(pc_i, instr_i);
        end
      end
      ST_COLLECT: begin
        rec_d = rec_upd;
        push  = instr_done;
        if (instr_start) begin
          // Without a retire, the partial record is abandoned.
          perr_set = !instr_done;
          rec_d    = fresh_rec(pc_i, instr_i);
        end else if (instr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rec_q   <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      ovf_q   <= ovf_q | drop;
      perr_q  <= perr_q | perr_set;
    end
  end

  fwrisc_trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .rec_i   (rec_upd),
    .pop_i   (trc_ready),
    .rec_o   (head),
    .valid_o (trc_ivalid),
    .drop_o  (drop)
  );

  assign trc_pc       = head.pc;
  assign trc_instr    = head.instr;
  assign trc_ra_raddr = head.ra_raddr;
  assign trc_ra_rdata = head.ra_rdata;
  assign trc_rb_raddr = head.rb_raddr;
  assign trc_rb_rdata = head.rb_rdata;
  assign trc_rd_waddr = head.rd_waddr;
  assign trc_rd_wdata = head.rd_wdata;
  assign trc_rd_write = head.rd_write;
  assign trc_maddr    = head.maddr;
  assign trc_mdata    = head.mdata;
  assign trc_mstrb    = head.mstrb;
  assign trc_mwrite   = head.mwrite;
  assign trc_mvalid   = head.mvalid;
  assign overflow     = ovf_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_fwrisc_trace_gen.sv
module tb_fwrisc_trace_gen;
  import fwrisc_trace_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_start, instr_done, trc_ready;
  logic [31:0] pc_i, instr_i;
  logic        ra_rd_v, rb_rd_v, rd_we;
  logic [5:0]  ra_raddr_i, rb_raddr_i, rd_waddr_i;
  logic [31:0] ra_rdata_i, rb_rdata_i, rd_wdata_i;
  logic        mvalid_i, mready_i, mwrite_i;
  logic [31:0] maddr_i, mdata_i;
  logic [3:0]  mstrb_i;
  logic [31:0] trc_pc, trc_instr, trc_ra_rdata, trc_rb_rdata, trc_rd_wdata, trc_maddr, trc_mdata;
  logic [5:0]  trc_ra_raddr, trc_rb_raddr, trc_rd_waddr;
  logic [3:0]  trc_mstrb;
  logic        trc_ivalid, trc_rd_write, trc_mwrite, trc_mvalid, overflow, protocol_err;

  fwrisc_trace_gen #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .instr_start(instr_start), .pc_i(pc_i), .instr_i(instr_i),
    .ra_rd_v(ra_rd_v), .rb_rd_v(rb_rd_v), .ra_raddr_i(ra_raddr_i), .rb_raddr_i(rb_raddr_i),
    .ra_rdata_i(ra_rdata_i), .rb_rdata_i(rb_rdata_i), .rd_we(rd_we), .rd_waddr_i(rd_waddr_i),
    .rd_wdata_i(rd_wdata_i), .mvalid_i(mvalid_i), .mready_i(mready_i), .mwrite_i(mwrite_i),
    .maddr_i(maddr_i), .mdata_i(mdata_i), .mstrb_i(mstrb_i), .instr_done(instr_done),
    .trc_ready(trc_ready), .trc_pc(trc_pc), .trc_instr(trc_instr), .trc_ivalid(trc_ivalid),
    .trc_ra_raddr(trc_ra_raddr), .trc_rb_raddr(trc_rb_raddr), .trc_rd_waddr(trc_rd_waddr),
    .trc_ra_rdata(trc_ra_rdata), .trc_rb_rdata(trc_rb_rdata), .trc_rd_wdata(trc_rd_wdata),
    .trc_rd_write(trc_rd_write), .trc_maddr(trc_maddr), .trc_mdata(trc_mdata),
    .trc_mstrb(trc_mstrb), .trc_mwrite(trc_mwrite), .trc_mvalid(trc_mvalid),
    .overflow(overflow), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state: expected records in order, buffered-record count,
  // expected sticky flags (committed after each edge, *_n predicted for next).
  trace_rec_t exp_q[$];
  trace_rec_t cur;
  bit         collecting = 1'b0;
  int         occ = 0, occ_n = 0;
  bit         ovf = 1'b0, ovf_n = 1'b0, perr = 1'b0, perr_n = 1'b0;
  bit         mon_en = 1'b0;

  trace_rec_t got;
  always_comb begin
    got.pc       = trc_pc;
    got.instr    = trc_instr;
    got.ra_raddr = trc_ra_raddr;
    got.ra_rdata = trc_ra_rdata;
    got.rb_raddr = trc_rb_raddr;
    got.rb_rdata = trc_rb_rdata;
    got.rd_waddr = trc_rd_waddr;
    got.rd_wdata = trc_rd_wdata;
    got.rd_write = trc_rd_write;
    got.maddr    = trc_maddr;
    got.mdata    = trc_mdata;
    got.mstrb    = trc_mstrb;
    got.mwrite   = trc_mwrite;
    got.mvalid   = trc_mvalid;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_rec(string name, trace_rec_t act, trace_rec_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got pc=%h rec=%h expected pc=%h rec=%h (t=%0t)",
               name, act.pc, act, req.pc, req, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clock) begin
    if (mon_en && reset) begin
      chk("ivalid", 32'(trc_ivalid), 32'(occ != 0));
      chk("overflow", 32'(overflow), 32'(ovf));
      chk("protocol_err", 32'(protocol_err), 32'(perr));
      if (trc_ivalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 32'(trc_ivalid), 32'd0);
        end else begin
          chk_rec("record", got, exp_q[0]);
          if (trc_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk_rec("idle_payload", got, '0);
      end
    end
  end

  function automatic trace_rec_t with_events(trace_rec_t r);
    trace_rec_t n = r;
    if (ra_rd_v) begin n.ra_raddr = ra_raddr_i; n.ra_rdata = ra_rdata_i; end
    if (rb_rd_v) begin n.rb_raddr = rb_raddr_i; n.rb_rdata = rb_rdata_i; end
    if (rd_we && rd_waddr_i != 0) begin
      n.rd_waddr = rd_waddr_i; n.rd_wdata = rd_wdata_i; n.rd_write = 1'b1;
    end
    if (mvalid_i && mready_i) begin
      n.maddr = maddr_i; n.mdata = mdata_i; n.mstrb = mstrb_i;
      n.mwrite = mwrite_i; n.mvalid = 1'b1;
    end
    return n;
  endfunction

  // Predict the effect of the currently driven inputs, then take one edge.
  task automatic edge_step();
    bit pop;
    pop    = (occ != 0) && trc_ready;
    occ_n  = occ - (pop ? 1 : 0);
    ovf_n  = ovf;
    perr_n = perr;
    if (instr_done) begin
      if (collecting) begin
        if (occ < DEPTH || pop) begin
          exp_q.push_back(with_events(cur));
          occ_n++;
        end else begin
          ovf_n = 1'b1;
        end
      end else begin
        perr_n = 1'b1;
      end
    end
    if (instr_start) begin
      if (collecting && !instr_done) perr_n = 1'b1;
      cur = '0;
      cur.pc = pc_i;
      cur.instr = instr_i;
      collecting = 1'b1;
    end else if (instr_done) begin
      collecting = 1'b0;
    end else if (collecting) begin
      cur = with_events(cur);
    end
    @(posedge clock);
    #1;
    occ  = occ_n;
    ovf  = ovf_n;
    perr = perr_n;
  endtask

  task automatic quiet();
    instr_start = 0; instr_done = 0; ra_rd_v = 0; rb_rd_v = 0; rd_we = 0;
    mvalid_i = 0; mready_i = 0; mwrite_i = 0;
    pc_i = '0; instr_i = '0; ra_raddr_i = '0; rb_raddr_i = '0; rd_waddr_i = '0;
    ra_rdata_i = '0; rb_rdata_i = '0; rd_wdata_i = '0;
    maddr_i = '0; mdata_i = '0; mstrb_i = '0;
  endtask

  task automatic noise();
    ra_rd_v = 1'($urandom); rb_rd_v = 1'($urandom); rd_we = 1'($urandom);
    mvalid_i = 1'($urandom); mready_i = 1'($urandom); mwrite_i = 1'($urandom);
    ra_raddr_i = 6'($urandom); rb_raddr_i = 6'($urandom);
    rd_waddr_i = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom);
    ra_rdata_i = $urandom; rb_rdata_i = $urandom; rd_wdata_i = $urandom;
    maddr_i = $urandom; mdata_i = $urandom; mstrb_i = 4'($urandom);
    pc_i = $urandom; instr_i = $urandom;
  endtask

  task automatic start(logic [31:0] pc);
    quiet(); instr_start = 1; pc_i = pc; instr_i = pc ^ 32'h00000013;
    edge_step();
  endtask

  task automatic rand_cycle(bit allow_err);
    noise();
    trc_ready = ($urandom_range(9) < 7);
    if (allow_err) begin
      instr_start = ($urandom_range(3) == 0);
      instr_done  = ($urandom_range(3) == 0);
    end else if (!collecting) begin
      instr_done  = 0;
      instr_start = ($urandom_range(2) == 0);
    end else begin
      instr_done  = ($urandom_range(3) == 0);
      instr_start = instr_done && ($urandom_range(1) == 1);
    end
    edge_step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    quiet();
    trc_ready = 1;
    #2;
    chk("reset_ivalid", 32'(trc_ivalid), 32'd0);
    chk("reset_pc", trc_pc, 32'd0);
    chk("reset_flags", {30'd0, overflow, protocol_err}, 32'd0);
    repeat (3) @(posedge clock);
    #4 reset = 1;
    @(posedge clock); #1;
    mon_en = 1;
    edge_step();

    // Register reads and write-back.
    start(32'h100);
    instr_i = 32'h00208033; // overrides nothing: start already taken
    quiet(); ra_rd_v = 1; ra_raddr_i = 1; ra_rdata_i = 5;
    rb_rd_v = 1; rb_raddr_i = 2; rb_rdata_i = 7;
    rd_we = 1; rd_waddr_i = 3; rd_wdata_i = 12;
    edge_step();
    quiet(); instr_done = 1;
    edge_step();
    quiet();
    chk("s1_ivalid", 32'(trc_ivalid), 32'd1);
    chk("s1_pc", trc_pc, 32'h100);
    chk("s1_rd_write", 32'(trc_rd_write), 32'd1);
    chk("s1_rd_wdata", trc_rd_wdata, 32'd12);
    chk("s1_mvalid", 32'(trc_mvalid), 32'd0);
    edge_step();

    // Write to x0 is not recorded.
    start(32'h104);
    quiet(); rd_we = 1; rd_waddr_i = 0; rd_wdata_i = 32'hFF;
    edge_step();
    quiet(); instr_done = 1;
    edge_step();
    quiet();
    chk("s2_rd_write", 32'(trc_rd_write), 32'd0);
    chk("s2_flags", {30'd0, overflow, protocol_err}, 32'd0);
    edge_step();

    // Store handshake in the retire cycle.
    start(32'h108);
    quiet(); instr_done = 1; mvalid_i = 1; mready_i = 1; mwrite_i = 1;
    maddr_i = 32'h2000; mdata_i = 32'hDEADBEEF; mstrb_i = 4'hF;
    edge_step();
    quiet();
    chk("s3_mvalid", 32'(trc_mvalid), 32'd1);
    chk("s3_mwrite", 32'(trc_mwrite), 32'd1);
    chk("s3_maddr", trc_maddr, 32'h2000);
    chk("s3_mdata", trc_mdata, 32'hDEADBEEF);
    chk("s3_mstrb", 32'(trc_mstrb), 32'hF);
    edge_step();

    // Three retirements into a depth-2 FIFO with the consumer stalled.
    trc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      start(32'h200 + 32'(4 * i));
      quiet(); instr_done = 1;
      edge_step();
    end
    quiet();
    repeat (3) edge_step();
    chk("s4_overflow", 32'(overflow), 32'd1);
    chk("s4_head_pc", trc_pc, 32'h200);
    trc_ready = 1;
    repeat (3) edge_step();

    // Back-to-back retire+start every cycle.
    start(32'h300);
    for (int i = 1; i <= 10; i++) begin
      quiet(); noise(); instr_done = 1; instr_start = 1; pc_i = 32'h300 + 32'(4 * i);
      edge_step();
    end
    quiet(); instr_done = 1;
    edge_step();
    quiet();
    repeat (3) edge_step();

    // Protocol-legal random traffic.
    for (int i = 0; i < 1500; i++) rand_cycle(1'b0);

    // Reset with one record buffered and another being collected.
    quiet(); trc_ready = 0;
    edge_step(); edge_step(); edge_step();
    start(32'h400);
    quiet(); instr_done = 1;
    edge_step();
    start(32'h404);
    reset = 0;
    #1;
    chk("s6_ivalid", 32'(trc_ivalid), 32'd0);
    chk("s6_flags", {30'd0, overflow, protocol_err}, 32'd0);
    exp_q.delete();
    occ = 0; ovf = 0; perr = 0; collecting = 0;
    @(posedge clock); #3;
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      noise(); instr_start = 0; instr_done = 0; trc_ready = 1'($urandom);
      edge_step();
    end

    // Random traffic including protocol violations.
    for (int i = 0; i < 400; i++) rand_cycle(1'b1);
    quiet(); trc_ready = 1;
    repeat (6) edge_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
